router_fsm_nch: RTL

Parametrised successor to the 3-channel router control FSM. It sequences header decode, payload load, full-stall and parity phases for a router with NUM_CH output FIFOs. It latches the destination address at the header instead of tracking `data_in` live, and discards packets addressed to non-existent channels. It also generates the per-channel soft-reset timeouts internally. It sits between the router input register, synchroniser and output FIFOs.

---
 rtl/router_fsm_nch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/router_fsm_nch.sv
// Router control FSM for NUM_CH output channels: header decode, payload load, full stall, parity, drop.
// Latency: Moore outputs follow the registered state; the first FIFO write comes two cycles after the header is accepted.
// Backpressure: busy holds the source while stalled; DROP_PACKET drains the source with busy low and no writes.
module router_fsm_nch #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              busy,
    output logic              write_enb_reg,
    output logic [ADDR_W-1:0] addr_q,
    output logic [NUM_CH-1:0] soft_reset
);

    localparam logic [3:0] ST_DECODE_ADDRESS     = 4'd0;
    localparam logic [3:0] ST_LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] ST_WAIT_TILL_EMPTY    = 4'd2;
    localparam logic [3:0] ST_LOAD_DATA          = 4'd3;
    localparam logic [3:0] ST_LOAD_PARITY        = 4'd4;
    localparam logic [3:0] ST_CHECK_PARITY_ERROR = 4'd5;
    localparam logic [3:0] ST_FIFO_FULL_STATE    = 4'd6;
    localparam logic [3:0] ST_LOAD_AFTER_FULL    = 4'd7;
    localparam logic [3:0] ST_DROP_PACKET        = 4'd8;

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] soft_d;

    // Channel-selected views: the live header channel and the latched destination.
    logic hdr_in_range, hdr_empty, hdr_soft;
    logic sel_full, sel_empty, sel_soft;

    // Select per-channel flags by header address and by latched address; out-of-range addresses see zeros.
    always_comb begin
        hdr_in_range = ({1'b0, data_in} < NUM_CH_L);
        hdr_empty    = 1'b0;
        hdr_soft     = 1'b0;
        sel_full     = 1'b0;
        sel_empty    = 1'b0;
        sel_soft     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (data_in == ADDR_W'(i)) begin
                hdr_empty = fifo_empty[i];
                hdr_soft  = soft_reset[i];
            end
            if (addr_q == ADDR_W'(i)) begin
                sel_full  = fifo_full[i];
                sel_empty = fifo_empty[i];
                sel_soft  = soft_reset[i];
            end
        end
    end

    // Per-channel watchdog: count consecutive unread-not-empty cycles, pulse soft reset on the last one.
    always_comb begin
        soft_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (!fifo_empty[i] && !read_enb[i]) begin
                if (cnt_q[i] == TO_LAST) begin
                    soft_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Next-state logic; a soft reset on the active channel abandons the packet from any state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q != ST_DECODE_ADDRESS && sel_soft) begin
            state_d = ST_DECODE_ADDRESS;
        end else begin
            case (state_q)
                ST_DECODE_ADDRESS: begin
                    // A header for a channel that is being soft-reset this cycle is held off.
                    if (pkt_valid && !(hdr_in_range && hdr_soft)) begin
                        addr_d = data_in;
                        if (!hdr_in_range)  state_d = ST_DROP_PACKET;
                        else if (hdr_empty) state_d = ST_LOAD_FIRST_DATA;
                        else                state_d = ST_WAIT_TILL_EMPTY;
                    end
                end
                ST_LOAD_FIRST_DATA: state_d = ST_LOAD_DATA;
                ST_WAIT_TILL_EMPTY: begin
                    if (sel_empty) state_d = ST_LOAD_FIRST_DATA;
                end
                ST_LOAD_DATA: begin
                    if (sel_full)        state_d = ST_FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = ST_LOAD_PARITY;
                end
                ST_FIFO_FULL_STATE: begin
                    if (!sel_full) state_d = ST_LOAD_AFTER_FULL;
                end
                ST_LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = ST_DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = ST_LOAD_PARITY;
                    else                    state_d = ST_LOAD_DATA;
                end
                ST_LOAD_PARITY: state_d = ST_CHECK_PARITY_ERROR;
                ST_CHECK_PARITY_ERROR: begin
                    if (sel_full) state_d = ST_FIFO_FULL_STATE;
                    else          state_d = ST_DECODE_ADDRESS;
                end
                ST_DROP_PACKET: begin
                    if (!pkt_valid) state_d = ST_DECODE_ADDRESS;
                end
                default: state_d = ST_DECODE_ADDRESS;
            endcase
        end
    end

    // State, latched destination, watchdog counters and soft-reset pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_DECODE_ADDRESS;
            addr_q     <= '0;
            soft_reset <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            soft_reset <= soft_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign detect_add    = (state_q == ST_DECODE_ADDRESS);
    assign lfd_state     = (state_q == ST_LOAD_FIRST_DATA);
    assign ld_state      = (state_q == ST_LOAD_DATA);
    assign laf_state     = (state_q == ST_LOAD_AFTER_FULL);
    assign full_state    = (state_q == ST_FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == ST_CHECK_PARITY_ERROR);
    assign drop_state    = (state_q == ST_DROP_PACKET);
    assign write_enb_reg = (state_q == ST_LOAD_DATA) || (state_q == ST_LOAD_PARITY)
                        || (state_q == ST_LOAD_AFTER_FULL);
    assign busy          = (state_q == ST_LOAD_FIRST_DATA) || (state_q == ST_WAIT_TILL_EMPTY)
                        || (state_q == ST_LOAD_PARITY) || (state_q == ST_CHECK_PARITY_ERROR)
                        || (state_q == ST_FIFO_FULL_STATE) || (state_q == ST_LOAD_AFTER_FULL);

endmodule
